seq_counter_fsm: RTL and testbench
==================================

Name: seq_counter_fsm

Overview:
- Parametrised Mealy pulse-sequence counter with an integrated multiplexed seven-segment display driver.
- Counts qualified `w` samples modulo `TARGET`. Raises `out` combinationally on the sample that completes a sequence, then wraps to zero.
- Counts completed sequences in a saturating hit counter.
- Time-multiplexes two hex digits (sequence state and hit count) onto one segment bus for the lab board.

Parameters:
- `WIDTH`, 3: bits of the state counter. Requires 2^`WIDTH` >= `TARGET`.
- `TARGET`, 5: number of qualified 1-samples per sequence; legal range 2..16.
- `MODE`, 0: 0 = cumulative (`w`=0 holds the count); 1 = consecutive (`w`=0 clears the count to 0).
- `HIT_W`, 4: width of the hit counter.
- `SCAN_DIV`, 16: clock cycles per display digit slot; legal range 2..65536.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `clr`, input, 1: reset, asynchronous, active-high.
- `w`, input, 1: serial input, sampled every cycle.
- `out`, output, 1: Mealy detect; equals `w` && (`state` == `TARGET`-1); combinational.
- `state`, output, `WIDTH`: current sequence count.
- `hits`, output, `HIT_W`: number of completed sequences, saturating.
- `seg`, output, 7: active-low segments; `seg[6]` = a down to `seg[0]` = g.
- `an`, output, 2: active-low digit enables; `an[0]` = state digit, `an[1]` = hit digit.

Behaviour:
- Reset (`clr`=1, asynchronous):
  - `state`=0, `hits`=0, scan counter=0, digit select=0.
  - `an`=2'b10, `seg`=7'b0000001 (glyph "0").
  - `out` = 0 regardless of `w`, because `state`=0 != `TARGET`-1.
  - Deasserting `clr` mid-sequence discards the partial count. The first rising edge after release counts normally.
- State update per rising edge:
  - `w`=1 and `state` < `TARGET`-1: `state` <= `state`+1.
  - `w`=1 and `state` == `TARGET`-1: `state` <= 0 (wrap). In the same cycle `out`=1 and the hit counter increments.
  - `w`=0, `MODE`=0: `state` holds.
  - `w`=0, `MODE`=1: `state` <= 0.
  - `state` >= `TARGET` is unreachable. If it is forced (X-recovery), the next edge loads 0.
- `out`: purely combinational from `w` and `state`; no registered latency. It may glitch with `w`; consumers sample it on the clock edge.
- Hit counter:
  - Increments on each edge where `out`=1.
  - Saturates at 2^`HIT_W`-1 and holds there until `clr`.
- Display scan:
  - The scan counter counts 0..`SCAN_DIV`-1 and wraps.
  - On wrap, the digit select toggles.
  - Select 0: `an`=2'b10, `seg` = glyph(`state`).
  - Select 1: `an`=2'b01, `seg` = glyph(`hits` low 4 bits).
  - Exactly one `an` bit is low at all times.
  - `an` and `seg` are registered together from the same select value, so they never show mismatched digit data.
  - Segment update latency is one cycle after a `state` or `hits` change.
- Glyph table (hex 0..F, active-low, a..g):
  - 0: 0000001
  - 1: 1001111
  - 2: 0010010
  - 3: 0000110
  - 4: 1001100
  - 5: 0100100
  - 6: 0100000
  - 7: 0001111
  - 8: 0000000
  - 9: 0000100
  - A: 0001000
  - b: 1100000
  - C: 0110001
  - d: 1000010
  - E: 0110000
  - F: 0111000
- Simultaneous events: `clr` overrides all. A sequence completion on the cycle the scan toggles updates both, with no lost increment.

Test Plan:
- Reset, then 5 clocks with `w`=1 (defaults): `state` sequence 1,2,3,4,0. `out`=1 only while `state`=4 and `w`=1. `hits`=1.
- `MODE`=0, `w` pattern 1,0,0,1,1,0,1,1: `state` goes 1,1,1,2,3,3,4,0. One `out` pulse on the final edge.
- `MODE`=1, `w` pattern 1,1,1,0,1,1,1,1,1: the `w`=0 cycle clears `state` to 0. `out` asserts only on the 9th sample; `hits`=1.
- `HIT_W`=2, 20 consecutive 1s with `TARGET`=5: `hits` goes 1,2,3, then holds at 3 on the 4th completion. `state` still wraps normally.
- `SCAN_DIV`=4, `state`=3 and `hits`=2 held: `an` alternates 10/01 every 4 clocks. `seg` alternates 0000110 / 0010010 in lockstep with `an`.
- Assert `clr` asynchronously between edges while `state`=3: `state`, `hits`, `an` and `seg` go to their reset values immediately, with no clock edge needed. `out` drops to 0 even with `w`=1.

Source files
------------

// File: rtl/seq_counter_fsm.sv
// Mealy pulse-sequence counter with saturating hit count and a two-digit
// multiplexed seven-segment driver (state digit / hit digit).
module seq_counter_fsm #(
  parameter int WIDTH    = 3,
  parameter int TARGET   = 5,
  parameter int MODE     = 0,
  parameter int HIT_W    = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             w,
  output logic             out,
  output logic [WIDTH-1:0] state,
  output logic [HIT_W-1:0] hits,
  output logic [6:0]       seg,
  output logic [1:0]       an
);

  localparam int                SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [WIDTH-1:0]  LAST      = WIDTH'(TARGET - 1);
  localparam logic [WIDTH:0]    TGT       = (WIDTH + 1)'(TARGET);
  localparam logic [HIT_W-1:0]  HIT_MAX   = '1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic {
    DIG_STATE = 1'b0,
    DIG_HITS  = 1'b1
  } dig_e;

  dig_e              dig_q, dig_d;
  logic [WIDTH-1:0]  state_d;
  logic [HIT_W-1:0]  hits_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [3:0]        nib;
  logic [6:0]        seg_d;
  logic [1:0]        an_d;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    state_d = state;
    out     = 1'b0;
    // Out-of-range codes (only reachable via X or forcing) fall back to 0.
    if ({1'b0, state} >= TGT) begin
      state_d = '0;
    end else if (w) begin
      if (state == LAST) begin
        state_d = '0;
        out     = 1'b1;
      end else begin
        state_d = state + 1'b1;
      end
    end else if (MODE == 1) begin
      state_d = '0;
    end

    hits_d = hits;
    if (out && (hits != HIT_MAX)) hits_d = hits + 1'b1;

    scan_d = scan_q + 1'b1;
    dig_d  = dig_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      dig_d  = (dig_q == DIG_STATE) ? DIG_HITS : DIG_STATE;
    end

    // an and seg both derive from dig_q so they always switch on the same edge.
    nib   = (dig_q == DIG_HITS) ? 4'(hits) : 4'(state);
    seg_d = glyph(nib);
    an_d  = (dig_q == DIG_HITS) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= '0;
      hits   <= '0;
      scan_q <= '0;
      dig_q  <= DIG_STATE;
      seg    <= 7'b0000001;
      an     <= 2'b10;
    end else begin
      state  <= state_d;
      hits   <= hits_d;
      scan_q <= scan_d;
      dig_q  <= dig_d;
      seg    <= seg_d;
      an     <= an_d;
    end
  end

endmodule

// File: tb/tb_seq_counter_fsm.sv
// Directed plus random bench for seq_counter_fsm; two instances (defaults,
// and MODE=1/HIT_W=2/SCAN_DIV=4) checked against an arithmetic reference.
module tb_seq_counter_fsm;

  localparam int TGT = 5;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       w   = 1'b0;

  logic       a_out, b_out;
  logic [2:0] a_state, b_state;
  logic [3:0] a_hits;
  logic [1:0] b_hits;
  logic [6:0] a_seg, b_seg;
  logic [1:0] a_an, b_an;

  int checks   = 0;
  int failures = 0;

  seq_counter_fsm #(.WIDTH(3), .TARGET(TGT), .MODE(0), .HIT_W(4), .SCAN_DIV(16)) u_a (
    .clk(clk), .clr(clr), .w(w), .out(a_out), .state(a_state),
    .hits(a_hits), .seg(a_seg), .an(a_an)
  );

  seq_counter_fsm #(.WIDTH(3), .TARGET(TGT), .MODE(1), .HIT_W(2), .SCAN_DIV(4)) u_b (
    .clk(clk), .clr(clr), .w(w), .out(b_out), .state(b_state),
    .hits(b_hits), .seg(b_seg), .an(b_an)
  );

  always #5 clk = ~clk;

  // Reference model: per-instance parameters and abstract counts.
  int         p_mode [2] = '{0, 1};
  int         p_hmax [2] = '{15, 3};
  int         p_sd   [2] = '{16, 4};
  int         m_cnt  [2];
  int         m_hits [2];
  int         m_n;
  logic [6:0] e_seg  [2];
  logic [1:0] e_an   [2];
  logic [6:0] glyph_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_hits[i] = 0;
      e_seg[i]  = 7'b0000001;
      e_an[i]   = 2'b10;
    end
    m_n = 0;
  endtask

  // One rising edge: display shows the digit selected by edges so far,
  // using values present before this edge.
  task automatic model_edge(input logic wv);
    for (int i = 0; i < 2; i++) begin
      int sel;
      bit hit;
      sel      = (m_n / p_sd[i]) % 2;
      e_seg[i] = sel ? glyph_tab[m_hits[i] % 16] : glyph_tab[m_cnt[i]];
      e_an[i]  = sel ? 2'b01 : 2'b10;
      hit      = wv && (m_cnt[i] == TGT - 1);
      if (wv) m_cnt[i] = (m_cnt[i] + 1) % TGT;
      else if (p_mode[i] == 1) m_cnt[i] = 0;
      if (hit && m_hits[i] < p_hmax[i]) m_hits[i]++;
    end
    m_n++;
  endtask

  task automatic check_regs();
    chk("a_state", 32'(a_state), 32'(m_cnt[0]));
    chk("a_hits",  32'(a_hits),  32'(m_hits[0]));
    chk("a_seg",   32'(a_seg),   32'(e_seg[0]));
    chk("a_an",    32'(a_an),    32'(e_an[0]));
    chk("b_state", 32'(b_state), 32'(m_cnt[1]));
    chk("b_hits",  32'(b_hits),  32'(m_hits[1]));
    chk("b_seg",   32'(b_seg),   32'(e_seg[1]));
    chk("b_an",    32'(b_an),    32'(e_an[1]));
  endtask

  task automatic step(input logic wv);
    @(negedge clk);
    w = wv;
    #1;
    chk("a_out", 32'(a_out), 32'(wv && m_cnt[0] == TGT - 1));
    chk("b_out", 32'(b_out), 32'(wv && m_cnt[1] == TGT - 1));
    @(posedge clk);
    model_edge(wv);
    #1;
    check_regs();
  endtask

  // Asynchronous clear between edges, with w=1 to show out is forced low.
  task automatic async_clear();
    @(negedge clk);
    w = 1'b1;
    #2 clr = 1'b1;
    #1;
    model_reset();
    chk("clr_a_state", 32'(a_state), 32'd0);
    chk("clr_a_hits",  32'(a_hits),  32'd0);
    chk("clr_a_an",    32'(a_an),    32'b10);
    chk("clr_a_seg",   32'(a_seg),   32'b0000001);
    chk("clr_a_out",   32'(a_out),   32'd0);
    chk("clr_b_state", 32'(b_state), 32'd0);
    chk("clr_b_hits",  32'(b_hits),  32'd0);
    chk("clr_b_out",   32'(b_out),   32'd0);
    @(posedge clk);
    #1 clr = 1'b0;
    check_regs();
  endtask

  logic [7:0] pat1 = 8'b11011001;   // applied LSB first: 1,0,0,1,1,0,1,1
  logic [8:0] pat2 = 9'b111110111;  // applied LSB first: 1,1,1,0,1,1,1,1,1

  initial begin
    async_clear();

    // Five ones: 1,2,3,4,0 with a single completion.
    for (int k = 0; k < 5; k++) step(1'b1);
    chk("seq5_state", 32'(a_state), 32'd0);
    chk("seq5_hits",  32'(a_hits),  32'd1);

    async_clear();
    for (int k = 0; k < 8; k++) step(pat1[k]);
    chk("cum_state", 32'(a_state), 32'd0);
    chk("cum_hits",  32'(a_hits),  32'd1);
    chk("cum_b_hits", 32'(b_hits), 32'd0);

    async_clear();
    for (int k = 0; k < 9; k++) step(pat2[k]);
    chk("con_b_state", 32'(b_state), 32'd0);
    chk("con_b_hits",  32'(b_hits),  32'd1);

    async_clear();
    for (int k = 0; k < 20; k++) step(1'b1);
    chk("sat_b_hits",  32'(b_hits),  32'd3);
    chk("sat_a_hits",  32'(a_hits),  32'd4);
    chk("sat_b_state", 32'(b_state), 32'd0);

    // Hold state=3, hits=2 on instance A and watch the digit scan.
    async_clear();
    for (int k = 0; k < 13; k++) step(1'b1);
    for (int k = 0; k < 40; k++) step(1'b0);
    chk("hold_a_state", 32'(a_state), 32'd3);
    chk("hold_a_hits",  32'(a_hits),  32'd2);
    async_clear();

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 79) == 0) async_clear();
      else step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
